// File: rtl/mem_port.sv
// Memory port: turns level-held controller requests into exactly one word-wide
// req/ack transaction, with lane steering, load extension and an ack timeout.
module mem_port #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] RESET_IR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        IRWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  input  logic [1:0]  Size,
  input  logic        Unsigned,
  output logic [31:0] ReadData,
  output logic [31:0] Instr,
  output logic        Busy,
  output logic        Done,
  output logic        AddrErr,
  output logic        BusErr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, HOLD = 2'd2} state_t;

  localparam logic [1:0]  SZ_WORD   = 2'b00;
  localparam logic [1:0]  SZ_HALF   = 2'b01;
  localparam logic [1:0]  SZ_BYTE   = 2'b10;
  localparam logic [1:0]  K_LOAD    = 2'd0;
  localparam logic [1:0]  K_STORE   = 2'd1;
  localparam logic [1:0]  K_FETCH   = 2'd2;
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  state_t      state_r;
  logic [1:0]  kind_r;
  logic [1:0]  size_r;
  logic [1:0]  lo_r;
  logic        uns_r;
  logic [15:0] wait_r;

  logic        req_any_s;
  logic [1:0]  kind_s;
  logic [1:0]  size_s;
  logic        misalign_s;
  logic [31:0] wdata_s;
  logic [3:0]  store_be_s;
  logic [3:0]  be_s;

  // Pick the addressed lane(s) out of a memory word, right-align and extend.
  function automatic logic [31:0] load_extract(input logic [31:0] rdata, input logic [1:0] lo,
                                               input logic [1:0] size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lo)
      2'b00:   b = rdata[7:0];
      2'b01:   b = rdata[15:8];
      2'b10:   b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = lo[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_HALF: r = {{16{h[15] & ~uns}}, h};
      SZ_BYTE: r = {{24{b[7] & ~uns}}, b};
      default: r = rdata;
    endcase
    return r;
  endfunction

  assign req_any_s = MemRead | MemWrite | IRWrite;

  // Decode the incoming request: type, effective size, alignment, lane data and enables.
  always_comb begin
    kind_s     = K_LOAD;
    size_s     = SZ_WORD;
    misalign_s = 1'b0;
    wdata_s    = WriteData;
    store_be_s = 4'b1111;
    be_s       = 4'b1111;
    if (MemWrite) begin
      kind_s = K_STORE;
    end else if (IRWrite) begin
      kind_s = K_FETCH;
    end else begin
      kind_s = K_LOAD;
    end
    // Fetches are always whole words; size code 11 also means word.
    if (kind_s == K_FETCH || Size == 2'b11) begin
      size_s = SZ_WORD;
    end else begin
      size_s = Size;
    end
    case (size_s)
      SZ_HALF: begin
        misalign_s = Addr[0];
        wdata_s    = {2{WriteData[15:0]}};
        store_be_s = Addr[1] ? 4'b1100 : 4'b0011;
      end
      SZ_BYTE: begin
        misalign_s = 1'b0;
        wdata_s    = {4{WriteData[7:0]}};
        store_be_s = 4'b0001 << Addr[1:0];
      end
      default: begin
        misalign_s = (Addr[1:0] != 2'b00);
        wdata_s    = WriteData;
        store_be_s = 4'b1111;
      end
    endcase
    if (kind_s == K_STORE) begin
      be_s = store_be_s;
    end else begin
      be_s = 4'b1111;
    end
  end

  // Transaction FSM with registered handshake, status pulses and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      kind_r    <= K_LOAD;
      size_r    <= SZ_WORD;
      lo_r      <= 2'b00;
      uns_r     <= 1'b0;
      wait_r    <= 16'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= 4'b0000;
      mem_addr  <= 32'h0000_0000;
      mem_wdata <= 32'h0000_0000;
      ReadData  <= 32'h0000_0000;
      Instr     <= RESET_IR;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      AddrErr   <= 1'b0;
      BusErr    <= 1'b0;
    end else begin
      Done    <= 1'b0;
      AddrErr <= 1'b0;
      BusErr  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req_any_s) begin
            kind_r <= kind_s;
            size_r <= size_s;
            lo_r   <= Addr[1:0];
            uns_r  <= Unsigned;
            wait_r <= 16'd0;
            if (misalign_s) begin
              AddrErr <= 1'b1;
              state_r <= HOLD;
            end else begin
              state_r   <= ACCESS;
              Busy      <= 1'b1;
              mem_req   <= 1'b1;
              mem_we    <= (kind_s == K_STORE);
              mem_addr  <= {Addr[31:2], 2'b00};
              mem_be    <= be_s;
              mem_wdata <= wdata_s;
            end
          end
        end
        ACCESS: begin
          // An ack in the final wait cycle still wins over the timeout.
          if (mem_ack) begin
            mem_req <= 1'b0;
            Busy    <= 1'b0;
            Done    <= 1'b1;
            state_r <= HOLD;
            case (kind_r)
              K_LOAD:  ReadData <= load_extract(mem_rdata, lo_r, size_r, uns_r);
              K_FETCH: Instr    <= mem_rdata;
              default: begin
              end
            endcase
          end else if (wait_r == WAIT_LAST) begin
            mem_req <= 1'b0;
            Busy    <= 1'b0;
            BusErr  <= 1'b1;
            state_r <= HOLD;
          end else begin
            wait_r <= wait_r + 16'd1;
          end
        end
        HOLD: begin
          if (!req_any_s) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port.sv
// Self-checking bench for mem_port: directed scenarios plus randomized
// transactions checked against a byte-lane reference model.
module tb_mem_port;

  localparam int          TMO  = 4;
  localparam logic [31:0] RIR  = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst, MemRead, MemWrite, IRWrite, Unsigned, mem_ack;
  logic [31:0] Addr, WriteData, mem_rdata;
  logic [1:0]  Size;
  logic [31:0] ReadData, Instr, mem_addr, mem_wdata;
  logic        Busy, Done, AddrErr, BusErr, mem_req, mem_we;
  logic [3:0]  mem_be;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_rd, exp_ir;

  // Observations of the last transaction
  int          o_rises, o_reqc, o_done, o_aerr, o_berr;
  logic        o_stable, o_busy_ok, o_excl_ok, o_we;
  logic [31:0] o_addr, o_wdata;
  logic [3:0]  o_be;

  typedef struct {
    int          aerr, berr, done, reqc;
    logic        we;
    logic [31:0] addr, wdata, rd, ir;
    logic [3:0]  be;
  } exp_t;

  mem_port #(.TIMEOUT(TMO), .RESET_IR(RIR)) dut (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .Addr(Addr), .WriteData(WriteData), .Size(Size), .Unsigned(Unsigned),
    .ReadData(ReadData), .Instr(Instr), .Busy(Busy), .Done(Done), .AddrErr(AddrErr),
    .BusErr(BusErr), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: treats the memory word as four bytes and the access as n bytes.
  function automatic exp_t model(input logic wr, input logic ir, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [1:0] sz, input logic un,
                                 input int dly, input logic [31:0] rdata,
                                 input logic [31:0] cur_rd, input logic [31:0] cur_ir);
    exp_t e;
    int n, lane;
    logic [31:0] v, mask;
    if (ir && !wr) n = 4;
    else if (sz == 2'd1) n = 2;
    else if (sz == 2'd2) n = 1;
    else n = 4;
    lane = int'(a % 32'd4);
    e.rd = cur_rd; e.ir = cur_ir;
    e.aerr = 0; e.berr = 0; e.done = 0; e.reqc = 0;
    e.we = wr;
    e.addr = a & 32'hFFFF_FFFC;
    e.be = wr ? 4'(((1 << n) - 1) << lane) : 4'hF;
    for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = wd[8*(i % n) +: 8];
    if (lane % n != 0) begin
      e.aerr = 1;
    end else if (dly >= TMO) begin
      e.berr = 1; e.reqc = TMO;
    end else begin
      e.done = 1; e.reqc = dly + 1;
      mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*n)) - 32'd1);
      v = (rdata >> (8*lane)) & mask;
      if (!un && n < 4 && v[8*n-1]) v = v | ~mask;
      if (!wr && ir) e.ir = rdata;
      else if (!wr) e.rd = v;
    end
    return e;
  endfunction

  // Drive one level-held request, play the memory side, record what the DUT did.
  task automatic run_txn(input logic wr, input logic ir, input logic rd, input logic [31:0] a,
                         input logic [31:0] wd, input logic [1:0] sz, input logic un,
                         input int dly, input logic [31:0] rdata);
    logic prev_req;
    int acc;
    @(negedge clk);
    MemWrite = wr; IRWrite = ir; MemRead = rd;
    Addr = a; WriteData = wd; Size = sz; Unsigned = un; mem_ack = 1'b0;
    prev_req = 1'b0; acc = 0;
    o_rises = 0; o_reqc = 0; o_done = 0; o_aerr = 0; o_berr = 0;
    o_stable = 1'b1; o_busy_ok = 1'b1; o_excl_ok = 1'b1;
    o_we = 1'b0; o_addr = 32'h0; o_wdata = 32'h0; o_be = 4'h0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      if (Busy !== mem_req) o_busy_ok = 1'b0;
      if (int'(Done) + int'(AddrErr) + int'(BusErr) > 1) o_excl_ok = 1'b0;
      o_done += int'(Done); o_aerr += int'(AddrErr); o_berr += int'(BusErr);
      if (mem_req === 1'b1) begin
        if (!prev_req) begin
          o_rises++;
          o_we = mem_we; o_addr = mem_addr; o_be = mem_be; o_wdata = mem_wdata;
        end else if ({mem_we, mem_addr, mem_be, mem_wdata} !== {o_we, o_addr, o_be, o_wdata}) begin
          o_stable = 1'b0;
        end
        o_reqc++;
        Addr = $urandom; WriteData = $urandom;
        Size = 2'($urandom_range(0, 3)); Unsigned = 1'($urandom_range(0, 1));
        mem_ack = (acc == dly);
        mem_rdata = mem_ack ? rdata : $urandom;
        acc++;
      end else begin
        mem_ack = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end
      prev_req = mem_req;
    end
    MemWrite = 1'b0; IRWrite = 1'b0; MemRead = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [73:0] outs;
    rst = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; IRWrite = 1'b0; Addr = 32'h0;
    WriteData = 32'h0; Size = 2'b00; Unsigned = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
    @(negedge clk);
    @(negedge clk);
    outs = {mem_req, mem_we, mem_be, mem_addr, mem_wdata, Busy, Done, AddrErr, BusErr};
    checks++; if (outs !== 74'd0) begin errors++; $display("FAIL reset_outs: got %h expected 0", outs); end
    checks++; if (ReadData !== 32'h0) begin errors++; $display("FAIL reset_rd: got %h expected 0", ReadData); end
    checks++; if (Instr !== RIR) begin errors++; $display("FAIL reset_ir: got %h expected %h", Instr, RIR); end
    rst = 1'b0;
    exp_rd = 32'h0; exp_ir = RIR;
  endtask

  task automatic test_fetch();
    run_txn(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 2'b10, 1'b0, 2, 32'h8C22_0004);
    checks++; if (o_addr !== 32'h100) begin errors++; $display("FAIL fetch_addr: got %h expected 100", o_addr); end
    checks++; if (o_be !== 4'hF || o_we !== 1'b0) begin errors++; $display("FAIL fetch_be_we: got %b/%b expected 1111/0", o_be, o_we); end
    checks++; if (Instr !== 32'h8C22_0004) begin errors++; $display("FAIL fetch_instr: got %h expected 8c220004", Instr); end
    checks++; if (o_done !== 1 || o_rises !== 1 || o_reqc !== 3) begin errors++;
      $display("FAIL fetch_once: done=%0d rises=%0d reqc=%0d expected 1 1 3", o_done, o_rises, o_reqc); end
    checks++; if (ReadData !== exp_rd) begin errors++; $display("FAIL fetch_rd_kept: got %h expected %h", ReadData, exp_rd); end
    exp_ir = 32'h8C22_0004;
  endtask

  task automatic test_byte_load();
    run_txn(1'b0, 1'b0, 1'b1, 32'h203, 32'h0, 2'b10, 1'b0, 0, 32'h80FF_1234);
    checks++; if (ReadData !== 32'hFFFF_FF80) begin errors++; $display("FAIL byte_signed: got %h expected ffffff80", ReadData); end
    run_txn(1'b0, 1'b0, 1'b1, 32'h203, 32'h0, 2'b10, 1'b1, 1, 32'h80FF_1234);
    checks++; if (ReadData !== 32'h0000_0080) begin errors++; $display("FAIL byte_unsigned: got %h expected 00000080", ReadData); end
    checks++; if (Instr !== exp_ir) begin errors++; $display("FAIL load_ir_kept: got %h expected %h", Instr, exp_ir); end
    exp_rd = 32'h0000_0080;
  endtask

  task automatic test_half_store();
    run_txn(1'b1, 1'b0, 1'b0, 32'h302, 32'h0000_ABCD, 2'b01, 1'b0, 1, 32'h1357_9BDF);
    checks++; if (o_we !== 1'b1 || o_addr !== 32'h300) begin errors++; $display("FAIL hstore_we_addr: got %b/%h expected 1/300", o_we, o_addr); end
    checks++; if (o_be !== 4'b1100) begin errors++; $display("FAIL hstore_be: got %b expected 1100", o_be); end
    checks++; if (o_wdata !== 32'hABCD_ABCD) begin errors++; $display("FAIL hstore_wdata: got %h expected abcdabcd", o_wdata); end
    checks++; if (ReadData !== exp_rd || Instr !== exp_ir) begin errors++;
      $display("FAIL hstore_regs_kept: got %h/%h expected %h/%h", ReadData, Instr, exp_rd, exp_ir); end
  endtask

  task automatic test_misaligned();
    run_txn(1'b0, 1'b0, 1'b1, 32'h401, 32'h0, 2'b00, 1'b0, 0, 32'h1111_2222);
    checks++; if (o_aerr !== 1 || o_done !== 0 || o_berr !== 0) begin errors++;
      $display("FAIL misalign_pulses: aerr=%0d done=%0d berr=%0d expected 1 0 0", o_aerr, o_done, o_berr); end
    checks++; if (o_rises !== 0) begin errors++; $display("FAIL misalign_noreq: got %0d expected 0", o_rises); end
    checks++; if (ReadData !== exp_rd) begin errors++; $display("FAIL misalign_rd_kept: got %h expected %h", ReadData, exp_rd); end
  endtask

  task automatic test_timeout();
    run_txn(1'b0, 1'b0, 1'b1, 32'h500, 32'h0, 2'b00, 1'b0, 100, 32'h0);
    checks++; if (o_reqc !== TMO) begin errors++; $display("FAIL timeout_reqc: got %0d expected %0d", o_reqc, TMO); end
    checks++; if (o_berr !== 1 || o_done !== 0) begin errors++; $display("FAIL timeout_pulse: berr=%0d done=%0d expected 1 0", o_berr, o_done); end
    checks++; if (o_rises !== 1 || !o_busy_ok) begin errors++; $display("FAIL timeout_hold: rises=%0d busy_ok=%b expected 1 1", o_rises, o_busy_ok); end
    checks++; if (ReadData !== exp_rd) begin errors++; $display("FAIL timeout_rd_kept: got %h expected %h", ReadData, exp_rd); end
  endtask

  task automatic test_priority_reset();
    logic [73:0] outs;
    bit seen;
    run_txn(1'b1, 1'b0, 1'b1, 32'h600, 32'h1122_3344, 2'b00, 1'b0, 1, 32'hCAFE_F00D);
    checks++; if (o_we !== 1'b1 || o_rises !== 1 || o_wdata !== 32'h1122_3344) begin errors++;
      $display("FAIL prio_store: we=%b rises=%0d wdata=%h expected 1 1 11223344", o_we, o_rises, o_wdata); end
    checks++; if (ReadData !== exp_rd) begin errors++; $display("FAIL prio_rd_kept: got %h expected %h", ReadData, exp_rd); end
    @(negedge clk);
    MemRead = 1'b1; Addr = 32'h700; Size = 2'b00; mem_ack = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5 && !seen; i++) begin
      @(negedge clk);
      seen = (mem_req === 1'b1);
    end
    checks++; if (!seen) begin errors++; $display("FAIL midrst_start: got no mem_req expected mem_req within 5 cycles"); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    outs = {mem_req, mem_we, mem_be, mem_addr, mem_wdata, Busy, Done, AddrErr, BusErr};
    checks++; if (outs !== 74'd0 || ReadData !== 32'h0 || Instr !== RIR) begin errors++;
      $display("FAIL midrst_outs: got %h rd=%h ir=%h expected 0 0 %h", outs, ReadData, Instr, RIR); end
    rst = 1'b0; MemRead = 1'b0;
    @(negedge clk);
    checks++; if (Done !== 1'b0 || BusErr !== 1'b0 || mem_req !== 1'b0) begin errors++;
      $display("FAIL midrst_after: done=%b berr=%b req=%b expected 0 0 0", Done, BusErr, mem_req); end
    exp_rd = 32'h0; exp_ir = RIR;
  endtask

  task automatic test_random();
    exp_t e;
    logic [2:0]  rq;
    logic [31:0] a, wd, rdata;
    logic [1:0]  sz;
    logic        un;
    int          dly;
    for (int it = 0; it < 40; it++) begin
      rq = 3'($urandom_range(1, 7));
      a = $urandom; wd = $urandom; rdata = $urandom;
      sz = 2'($urandom_range(0, 3)); un = 1'($urandom_range(0, 1));
      dly = $urandom_range(0, 5);
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      e = model(rq[2], rq[1], a, wd, sz, un, dly, rdata, exp_rd, exp_ir);
      run_txn(rq[2], rq[1], rq[0], a, wd, sz, un, dly, rdata);
      checks++; if (o_aerr !== e.aerr || o_berr !== e.berr || o_done !== e.done) begin errors++;
        $display("FAIL rnd_pulses it=%0d: got %0d%0d%0d expected %0d%0d%0d", it, o_aerr, o_berr, o_done, e.aerr, e.berr, e.done); end
      checks++; if (o_reqc !== e.reqc || o_rises !== (e.reqc > 0 ? 1 : 0)) begin errors++;
        $display("FAIL rnd_reqc it=%0d: got %0d/%0d expected %0d", it, o_reqc, o_rises, e.reqc); end
      if (e.reqc > 0) begin
        checks++; if ({o_we, o_addr, o_be} !== {e.we, e.addr, e.be}) begin errors++;
          $display("FAIL rnd_cmd it=%0d: got %b %h %b expected %b %h %b", it, o_we, o_addr, o_be, e.we, e.addr, e.be); end
        if (e.we) begin
          checks++; if (o_wdata !== e.wdata) begin errors++; $display("FAIL rnd_wdata it=%0d: got %h expected %h", it, o_wdata, e.wdata); end
        end
      end
      checks++; if (!o_stable || !o_busy_ok || !o_excl_ok) begin errors++;
        $display("FAIL rnd_proto it=%0d: stable=%b busy=%b excl=%b expected 111", it, o_stable, o_busy_ok, o_excl_ok); end
      checks++; if (ReadData !== e.rd || Instr !== e.ir) begin errors++;
        $display("FAIL rnd_regs it=%0d: got %h/%h expected %h/%h", it, ReadData, Instr, e.rd, e.ir); end
      exp_rd = e.rd; exp_ir = e.ir;
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_byte_load();
    test_half_store();
    test_misaligned();
    test_timeout();
    test_priority_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
